// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB state machine sharing one
// req/ready memory port for instructions and data; unsupported encodings park it in HALT.
module multicycle_cpu #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int NUM_REGS      = 32,
    parameter int RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ready,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic                     halted,
    output logic                     instr_done,
    output logic [2:0]               dbg_state
);
    // Memory handshake: a transfer completes on the rising edge where mem_req and
    // mem_ready are both 1; mem_addr/mem_we/mem_wdata hold steady until that edge.
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [RW-1:0]            A0_IDX  = RW'(10);
    localparam logic [ADDRESS_WIDTH-1:0] PC0     = ADDRESS_WIDTH'(RESET_PC);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                   r_state, w_next;
    logic [31:0]              r_ir;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0]    r_a, r_b, r_imm, r_alu_out, r_mdr;
    logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];

    logic [6:0]            w_op, w_f7;
    logic [2:0]            w_f3;
    logic [RW-1:0]         w_rs1, w_rs2, w_rd;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_legal, w_taken, w_is_st;

    assign w_op    = r_ir[6:0];
    assign w_f3    = r_ir[14:12];
    assign w_f7    = r_ir[31:25];
    assign w_rd    = r_ir[7 +: RW];
    assign w_rs1   = r_ir[15 +: RW];
    assign w_rs2   = r_ir[20 +: RW];
    assign w_is_st = (w_op == OP_ST);
    assign w_taken = w_f3[0] ? (r_a != r_b) : (r_a == r_b);

    assign pc        = r_pc;
    assign a0        = r_regs[A0_IDX];
    assign dbg_state = r_state;

    always_comb begin
        w_imm = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[31:20]};
        if (w_op == OP_ST)
            w_imm = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        else if (w_op == OP_BR)
            w_imm = {{(DATA_WIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    end

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_R:         w_legal = (w_f3 == 3'b000) && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000));
            OP_I:         w_legal = (w_f3 == 3'b000);
            OP_LD, OP_ST: w_legal = (w_f3 == 3'b010);
            OP_BR:        w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001);
            default:      w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    // mem_req is gated by rst so an in-flight transfer is dropped the moment reset asserts.
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = r_pc;
        mem_wdata  = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = rst;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_op == OP_BR) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else if ((w_op == OP_LD) || w_is_st) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = rst;
                mem_we   = rst && w_is_st;
                mem_addr = r_alu_out[ADDRESS_WIDTH-1:0];
                if (w_is_st) mem_wdata = r_b;
                if (mem_ready) begin
                    instr_done = w_is_st;
                    w_next     = w_is_st ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= PC0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) r_ir <= mem_rdata[31:0];
                S_DECODE: begin
                    r_a   <= r_regs[w_rs1];
                    r_b   <= r_regs[w_rs2];
                    r_imm <= w_imm;
                end
                S_EXEC: begin
                    if (w_op == OP_BR)
                        r_pc <= r_pc + (w_taken ? r_imm[ADDRESS_WIDTH-1:0] : PC_STEP);
                    else if (w_op == OP_R)
                        r_alu_out <= w_f7[5] ? (r_a - r_b) : (r_a + r_b);
                    else
                        r_alu_out <= r_a + r_imm;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_st) r_pc  <= r_pc + PC_STEP;
                        else         r_mdr <= mem_rdata;
                    end
                end
                S_WB: begin
                    // x0 is never written, so it keeps reading back as zero.
                    if (w_rd != '0) r_regs[w_rd] <= (w_op == OP_LD) ? r_mdr : r_alu_out;
                    r_pc <= r_pc + PC_STEP;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: per-instruction vector tables (PC, a0, latency)
// plus hand sequences for reset, wait states, illegal-instruction halt and mid-fetch reset.
module tb_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, halted, instr_done;
    logic [7:0]  mem_addr, pc;
    logic [31:0] mem_wdata, mem_rdata, a0;
    logic        mem_ready;
    logic [2:0]  dbg_state;

    multicycle_cpu #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(8), .NUM_REGS(32), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .a0(a0), .halted(halted), .instr_done(instr_done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: 64 words, n_wait wait cycles per transfer or always-ready.
    logic [31:0] mem [64];
    int          n_wait   = 0;
    bit          ready_all = 1'b1;
    int          w_cnt    = 0;

    assign mem_rdata = mem[mem_addr[7:2]];
    assign mem_ready = ready_all | (mem_req & (w_cnt >= n_wait));

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            w_cnt <= 0;
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        end else if (mem_req) begin
            w_cnt <= w_cnt + 1;
        end else begin
            w_cnt <= 0;
        end
    end

    // Store monitor and instr_done pulse counter.
    int          st_cycles = 0, st_unstable = 0, done_cnt = 0;
    logic [7:0]  st_addr = '0;
    logic [31:0] st_data = '0;

    always @(negedge clk) begin
        if (instr_done) done_cnt++;
        if (rst && mem_req && mem_we) begin
            if (st_cycles == 0) begin
                st_addr = mem_addr;
                st_data = mem_wdata;
            end else if (mem_addr !== st_addr || mem_wdata !== st_data) begin
                st_unstable++;
            end
            st_cycles++;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd, input logic [6:0] op, input logic [2:0] f3);
        logic [11:0] im = imm[11:0];
        logic [4:0]  r1 = rs1[4:0];
        logic [4:0]  d  = rd[4:0];
        return {im, r1, f3, d, op};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, rd, 7'b0010011, 3'b000);
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input int rd);
        logic [4:0] r2 = rs2[4:0];
        logic [4:0] r1 = rs1[4:0];
        logic [4:0] d  = rd[4:0];
        return {f7, r2, r1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        logic [11:0] im = imm[11:0];
        logic [4:0]  r2 = rs2[4:0];
        logic [4:0]  r1 = rs1[4:0];
        return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        logic [12:0] im = imm[12:0];
        logic [4:0]  r2 = rs2[4:0];
        logic [4:0]  r1 = rs1[4:0];
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [31:0] a0;
        logic [7:0]  npc;
        int          cyc;
    } vec_t;

    vec_t vec [8];

    function automatic void set_vec(input int i, input logic [7:0] p, input logic [31:0] ins,
                                    input logic [31:0] ea0, input logic [7:0] np, input int c);
        vec[i] = '{p, ins, ea0, np, c};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic load_vecs(input int n);
        for (int i = 0; i < n; i++) mem[vec[i].pc[7:2]] = vec[i].instr;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic release_reset(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, " rst pc"},         {24'd0, pc}, 32'h0);
        chk({tag, " rst mem_req"},    {31'd0, mem_req}, 32'h0);
        chk({tag, " rst mem_we"},     {31'd0, mem_we}, 32'h0);
        chk({tag, " rst a0"},         a0, 32'h0);
        chk({tag, " rst halted"},     {31'd0, halted}, 32'h0);
        chk({tag, " rst instr_done"}, {31'd0, instr_done}, 32'h0);
        chk({tag, " rst mem_addr"},   {24'd0, mem_addr}, 32'h0);
        chk({tag, " rst mem_wdata"},  mem_wdata, 32'h0);
        rst = 1'b1;
        #1;
        chk({tag, " first fetch req"},  {31'd0, mem_req}, 32'h1);
        chk({tag, " first fetch addr"}, {24'd0, mem_addr}, 32'h0);
    endtask

    // Starts in the first cycle of an instruction; returns in the first cycle of the next.
    task automatic run_instr(input string tag, output int cyc);
        bit done = 1'b0;
        cyc = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            cyc++;
            if (instr_done) done = 1'b1;
            else @(negedge clk);
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: no instr_done within 60 cycles", tag);
        end
        @(negedge clk);
    endtask

    task automatic run_vecs(input int n, input string tag, output int total);
        int c;
        total = 0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] start pc", tag, i), {24'd0, pc}, {24'd0, vec[i].pc});
            run_instr($sformatf("%s[%0d]", tag, i), c);
            total += c;
            chk($sformatf("%s[%0d] a0", tag, i), a0, vec[i].a0);
            chk($sformatf("%s[%0d] pc", tag, i), {24'd0, pc}, {24'd0, vec[i].npc});
            chk($sformatf("%s[%0d] cycles", tag, i), c, vec[i].cyc);
        end
    endtask

    initial begin
        int total, c;

        // ALU program, zero wait states.
        ready_all = 1'b1; n_wait = 0;
        set_vec(0, 8'h00, addi(10, 0, 5),                  32'd5, 8'h04, 4);
        set_vec(1, 8'h04, addi(11, 0, -3),                 32'd5, 8'h08, 4);
        set_vec(2, 8'h08, enc_r(7'b0000000, 11, 10, 10),   32'd2, 8'h0C, 4);
        set_vec(3, 8'h0C, enc_r(7'b0100000, 11, 10, 10),   32'd5, 8'h10, 4);
        clear_mem(); load_vecs(4);
        release_reset("alu");
        done_cnt = 0;
        run_vecs(4, "alu", total);
        chk("alu total cycles", total, 16);
        chk("alu instr_done pulses", done_cnt, 4);

        // Load/store with two wait cycles per transfer.
        hold_reset();
        ready_all = 1'b0; n_wait = 2;
        set_vec(0, 8'h00, addi(10, 0, 32'h123), 32'h123, 8'h04, 6);
        set_vec(1, 8'h04, addi(5, 0, 32'h40),   32'h123, 8'h08, 6);
        set_vec(2, 8'h08, sw(10, 5, 4),         32'h123, 8'h0C, 8);
        set_vec(3, 8'h0C, addi(10, 0, 0),       32'h0,   8'h10, 6);
        set_vec(4, 8'h10, enc_i(4, 5, 10, 7'b0000011, 3'b010), 32'h123, 8'h14, 9);
        clear_mem(); load_vecs(5);
        mem[17] = 32'hDEAD_BEEF;
        st_cycles = 0; st_unstable = 0;
        release_reset("ls");
        run_vecs(5, "ls", total);
        chk("ls store addr", {24'd0, st_addr}, 32'h44);
        chk("ls store data", st_data, 32'h123);
        chk("ls store we cycles", st_cycles, 3);
        chk("ls store stable", st_unstable, 0);
        chk("ls memory word", mem[17], 32'h123);

        // Countdown loop with BNE.
        hold_reset();
        ready_all = 1'b1; n_wait = 0;
        set_vec(0, 8'h00, addi(10, 0, 3),              32'd3, 8'h04, 4);
        set_vec(1, 8'h04, addi(10, 10, -1),            32'd2, 8'h08, 4);
        set_vec(2, 8'h08, enc_b(3'b001, 10, 0, -4),    32'd2, 8'h04, 3);
        set_vec(3, 8'h04, addi(10, 10, -1),            32'd1, 8'h08, 4);
        set_vec(4, 8'h08, enc_b(3'b001, 10, 0, -4),    32'd1, 8'h04, 3);
        set_vec(5, 8'h04, addi(10, 10, -1),            32'd0, 8'h08, 4);
        set_vec(6, 8'h08, enc_b(3'b001, 10, 0, -4),    32'd0, 8'h0C, 3);
        clear_mem(); load_vecs(7);
        release_reset("loop");
        run_vecs(7, "loop", total);

        // BEQ wrapping the PC past 0xFF, then a not-taken BEQ.
        hold_reset();
        set_vec(0, 8'h00, enc_b(3'b000, 0, 0, 248),    32'd0, 8'hF8, 3);
        set_vec(1, 8'hF8, enc_b(3'b000, 0, 0, 12),     32'd0, 8'h04, 3);
        set_vec(2, 8'h04, addi(10, 0, 9),              32'd9, 8'h08, 4);
        set_vec(3, 8'h08, enc_b(3'b000, 10, 0, 100),   32'd9, 8'h0C, 3);
        clear_mem(); load_vecs(4);
        release_reset("wrap");
        run_vecs(4, "wrap", total);

        // Writes to x0 are discarded.
        hold_reset();
        set_vec(0, 8'h00, addi(10, 0, 1),                 32'd1, 8'h04, 4);
        set_vec(1, 8'h04, addi(0, 0, 7),                  32'd1, 8'h08, 4);
        set_vec(2, 8'h08, enc_r(7'b0000000, 0, 0, 10),    32'd0, 8'h0C, 4);
        clear_mem(); load_vecs(3);
        release_reset("x0");
        run_vecs(3, "x0", total);

        // Illegal instruction: sticky halt, then cleared by reset.
        hold_reset();
        clear_mem();
        mem[0] = 32'hFFFF_FFFF;
        release_reset("ill");
        c = 0;
        for (int k = 0; k < 10 && !halted; k++) begin
            c++;
            @(negedge clk);
        end
        c++;
        chk("ill cycles to halt", c, 3);
        repeat (4) @(negedge clk);
        chk("ill halted sticky", {31'd0, halted}, 32'h1);
        chk("ill mem_req low", {31'd0, mem_req}, 32'h0);
        chk("ill pc frozen", {24'd0, pc}, 32'h0);
        chk("ill no instr_done", {31'd0, instr_done}, 32'h0);
        hold_reset();
        mem[0] = addi(10, 0, 5);
        #1;
        chk("ill halted cleared by rst", {31'd0, halted}, 32'h0);
        release_reset("ill2");
        run_instr("ill refetch", c);
        chk("ill refetch a0", a0, 32'd5);
        chk("ill refetch pc", {24'd0, pc}, 32'h4);

        // Reset asserted in the middle of a waiting fetch.
        hold_reset();
        ready_all = 1'b0; n_wait = 5;
        release_reset("mid");
        @(negedge clk);
        chk("mid req before rst", {31'd0, mem_req}, 32'h1);
        #3 rst = 1'b0;
        #1;
        chk("mid req drops async", {31'd0, mem_req}, 32'h0);
        chk("mid pc at reset", {24'd0, pc}, 32'h0);
        chk("mid a0 cleared", a0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
